pingpong_frame_writer: RTL and testbench

Parametrised multi-bank frame writer for the convolution input buffer. It accepts a pixel stream and writes it into one shared RAM split into NUM_BANKS equal banks, one frame per bank, in round-robin order. Each frame is IMG_H rows of IMG_W valid pixels, stored at a row pitch of PITCH so that unused columns are skipped. It tracks which banks are full, exposes the oldest full bank to the convolution reader, and recycles a bank when the reader releases it.

---
 rtl/pingpong_frame_writer.sv | 157 +++++++++++++++
 tb/tb_pingpong_frame_writer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_writer.sv
// Multi-bank frame writer: streams pixels into NUM_BANKS round-robin frame banks of a shared RAM
// and hands completed frames, oldest first, to the convolution reader.
module pingpong_frame_writer #(
  parameter int DATA_W    = 16,
  parameter int IMG_W     = 8,
  parameter int PITCH     = 9,
  parameter int IMG_H     = 9,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validData,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              frameAbort,
  input  logic              bankRelease,
  output logic              wEn,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  output logic              readyForData,
  output logic              validToRead,
  output logic [1:0]        readBank,
  output logic [2:0]        fullCount,
  output logic              overflow,
  output logic              underflow
);

  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(PITCH - IMG_W + 1);
  localparam logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(PITCH * IMG_H);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [1:0]        BANK_LAST = 2'(NUM_BANKS - 1);
  localparam logic [2:0]        FULL      = 3'(NUM_BANKS);

  typedef enum logic {FILL, STALL} state_t;

  state_t            stateReg, stateNext;
  logic [ROW_W-1:0]  rowReg, rowNext;
  logic [COL_W-1:0]  colReg, colNext;
  logic [1:0]        wBankReg, wBankNext, rBankReg, rBankNext;
  logic [2:0]        fullCountReg, fullCountNext;
  logic [ADDR_W-1:0] addrPtrReg, addrPtrNext, bankBaseReg, bankBaseNext;
  logic              wEnReg, wEnNext;
  logic [ADDR_W-1:0] wAddrReg, wAddrNext;
  logic [DATA_W-1:0] wDataReg, wDataNext;
  logic              overflowReg, overflowNext, underflowReg, underflowNext;

  logic accept, relValid, rowEnd, frameEnd, lastPix;

  assign accept   = validData && (stateReg == FILL) && !frameAbort;
  assign relValid = bankRelease && (fullCountReg != 3'd0);
  assign rowEnd   = (colReg == COL_LAST);
  assign frameEnd = rowEnd && (rowReg == ROW_LAST);
  assign lastPix  = accept && frameEnd;

  always_comb begin
    stateNext     = stateReg;
    rowNext       = rowReg;
    colNext       = colReg;
    wBankNext     = wBankReg;
    rBankNext     = rBankReg;
    addrPtrNext   = addrPtrReg;
    bankBaseNext  = bankBaseReg;
    wEnNext       = 1'b0;
    wAddrNext     = wAddrReg;
    wDataNext     = wDataReg;
    overflowNext  = overflowReg;
    underflowNext = underflowReg;

    // addrPtrReg always holds the address of the next pixel, so no multiply is needed.
    if (frameAbort) begin
      rowNext     = '0;
      colNext     = '0;
      addrPtrNext = bankBaseReg;
    end else if (accept) begin
      wEnNext   = 1'b1;
      wAddrNext = addrPtrReg;
      wDataNext = dataIn;
      if (!rowEnd) begin
        colNext     = colReg + 1'b1;
        addrPtrNext = addrPtrReg + 1'b1;
      end else if (!frameEnd) begin
        colNext     = '0;
        rowNext     = rowReg + 1'b1;
        addrPtrNext = addrPtrReg + ROW_STEP;
      end else begin
        colNext = '0;
        rowNext = '0;
        if (wBankReg == BANK_LAST) begin
          wBankNext    = 2'd0;
          bankBaseNext = '0;
          addrPtrNext  = '0;
        end else begin
          wBankNext    = wBankReg + 1'b1;
          bankBaseNext = bankBaseReg + BANK_SIZE;
          addrPtrNext  = bankBaseReg + BANK_SIZE;
        end
      end
    end else if (validData) begin
      overflowNext = 1'b1;
    end

    if (relValid) begin
      rBankNext = (rBankReg == BANK_LAST) ? 2'd0 : rBankReg + 1'b1;
    end else if (bankRelease) begin
      underflowNext = 1'b1;
    end

    fullCountNext = fullCountReg + {2'b00, lastPix} - {2'b00, relValid};
    stateNext     = (fullCountNext == FULL) ? STALL : FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= FILL;
      rowReg       <= '0;
      colReg       <= '0;
      wBankReg     <= '0;
      rBankReg     <= '0;
      fullCountReg <= '0;
      addrPtrReg   <= '0;
      bankBaseReg  <= '0;
      wEnReg       <= 1'b0;
      wAddrReg     <= '0;
      wDataReg     <= '0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      rowReg       <= rowNext;
      colReg       <= colNext;
      wBankReg     <= wBankNext;
      rBankReg     <= rBankNext;
      fullCountReg <= fullCountNext;
      addrPtrReg   <= addrPtrNext;
      bankBaseReg  <= bankBaseNext;
      wEnReg       <= wEnNext;
      wAddrReg     <= wAddrNext;
      wDataReg     <= wDataNext;
      overflowReg  <= overflowNext;
      underflowReg <= underflowNext;
    end
  end

  assign wEn          = wEnReg;
  assign wAddr        = wAddrReg;
  assign wData        = wDataReg;
  assign readyForData = (stateReg == FILL);
  assign validToRead  = (fullCountReg != 3'd0);
  assign readBank     = rBankReg;
  assign fullCount    = fullCountReg;
  assign overflow     = overflowReg;
  assign underflow    = underflowReg;

endmodule

// File: tb/tb_pingpong_frame_writer.sv
// Directed bench for pingpong_frame_writer: frame fill, stall/overflow, release, abort and reset cases
// with expected addresses computed from the bank/row/column layout.
module tb_pingpong_frame_writer;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 8;
  localparam int PITCH  = 9;
  localparam int IMG_H  = 9;
  localparam int ADDR_W = 10;
  localparam int FRAME  = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset;
  logic              validData;
  logic [DATA_W-1:0] dataIn;
  logic              frameAbort;
  logic              bankRelease;
  logic              wEn;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              readyForData;
  logic              validToRead;
  logic [1:0]        readBank;
  logic [2:0]        fullCount;
  logic              overflow;
  logic              underflow;

  int checkCount = 0;
  int passCount  = 0;
  logic [DATA_W-1:0] pixVal = 16'hA000;

  pingpong_frame_writer #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .PITCH(PITCH), .IMG_H(IMG_H), .NUM_BANKS(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .validData(validData), .dataIn(dataIn),
    .frameAbort(frameAbort), .bankRelease(bankRelease),
    .wEn(wEn), .wAddr(wAddr), .wData(wData), .readyForData(readyForData),
    .validToRead(validToRead), .readBank(readBank), .fullCount(fullCount),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pixAddr(input int bank, input int n);
    return bank * PITCH * IMG_H + (n / IMG_W) * PITCH + (n % IMG_W);
  endfunction

  task automatic pushPixel(input int expAddr);
    validData = 1'b1;
    dataIn    = pixVal;
    step();
    validData = 1'b0;
    $display("pixel data=%04h addr=%0d (expected %0d) wEn=%0b", pixVal, wAddr, expAddr, wEn);
    checkValue("pix_wEn", 32'(wEn), 32'd1);
    checkValue("pix_wAddr", 32'(wAddr), 32'(expAddr));
    checkValue("pix_wData", 32'(wData), 32'(pixVal));
    pixVal = pixVal + 16'd1;
  endtask

  task automatic pushFrame(input int bank, input int count);
    for (int n = 0; n < count; n++) pushPixel(pixAddr(bank, n));
  endtask

  task automatic applyReset();
    reset = 1'b1;
    validData = 1'b0;
    frameAbort = 1'b0;
    bankRelease = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    $display("reset check %s", tag);
    checkValue({tag, "_wEn"}, 32'(wEn), 32'd0);
    checkValue({tag, "_wAddr"}, 32'(wAddr), 32'd0);
    checkValue({tag, "_wData"}, 32'(wData), 32'd0);
    checkValue({tag, "_ready"}, 32'(readyForData), 32'd1);
    checkValue({tag, "_validToRead"}, 32'(validToRead), 32'd0);
    checkValue({tag, "_readBank"}, 32'(readBank), 32'd0);
    checkValue({tag, "_fullCount"}, 32'(fullCount), 32'd0);
    checkValue({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkValue({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1; validData = 1'b0; dataIn = '0; frameAbort = 1'b0; bankRelease = 1'b0;
    step();
    applyReset();
    checkReset("rst0");

    // Two full frames, then stall with overflow.
    pushFrame(0, FRAME);
    checkValue("f0_fullCount", 32'(fullCount), 32'd1);
    checkValue("f0_validToRead", 32'(validToRead), 32'd1);
    checkValue("f0_readBank", 32'(readBank), 32'd0);
    checkValue("f0_ready", 32'(readyForData), 32'd1);
    pushFrame(1, FRAME);
    checkValue("f1_fullCount", 32'(fullCount), 32'd2);
    checkValue("f1_ready", 32'(readyForData), 32'd0);
    validData = 1'b1; dataIn = 16'hDEAD;
    step();
    validData = 1'b0;
    $display("stalled pixel wEn=%0b wAddr=%0d overflow=%0b", wEn, wAddr, overflow);
    checkValue("stall_wEn", 32'(wEn), 32'd0);
    checkValue("stall_wAddr", 32'(wAddr), 32'd160);
    checkValue("stall_overflow", 32'(overflow), 32'd1);
    checkValue("stall_fullCount", 32'(fullCount), 32'd2);

    bankRelease = 1'b1;
    step();
    bankRelease = 1'b0;
    $display("release fullCount=%0d readBank=%0d ready=%0b", fullCount, readBank, readyForData);
    checkValue("rel_fullCount", 32'(fullCount), 32'd1);
    checkValue("rel_readBank", 32'(readBank), 32'd1);
    checkValue("rel_ready", 32'(readyForData), 32'd1);
    pushPixel(0);

    // Last pixel of a frame coinciding with a release.
    applyReset();
    checkReset("rst1");
    pushFrame(0, FRAME);
    pushFrame(1, FRAME - 1);
    validData = 1'b1; bankRelease = 1'b1; dataIn = pixVal;
    step();
    validData = 1'b0; bankRelease = 1'b0;
    $display("last+release wAddr=%0d fullCount=%0d readBank=%0d", wAddr, fullCount, readBank);
    checkValue("coin_wEn", 32'(wEn), 32'd1);
    checkValue("coin_wAddr", 32'(wAddr), 32'd160);
    checkValue("coin_fullCount", 32'(fullCount), 32'd1);
    checkValue("coin_readBank", 32'(readBank), 32'd1);
    checkValue("coin_ready", 32'(readyForData), 32'd1);
    pixVal = pixVal + 16'd1;
    pushPixel(0);

    // Abort mid-frame, then an underflowing release.
    applyReset();
    pushFrame(0, 20);
    checkValue("pre_abort_wAddr", 32'(wAddr), 32'd21);
    frameAbort = 1'b1; validData = 1'b1; dataIn = 16'hBEEF;
    step();
    frameAbort = 1'b0; validData = 1'b0;
    $display("abort wEn=%0b overflow=%0b", wEn, overflow);
    checkValue("abort_wEn", 32'(wEn), 32'd0);
    checkValue("abort_overflow", 32'(overflow), 32'd0);
    pushPixel(0);
    bankRelease = 1'b1;
    step();
    bankRelease = 1'b0;
    $display("empty release underflow=%0b readBank=%0d", underflow, readBank);
    checkValue("uf_underflow", 32'(underflow), 32'd1);
    checkValue("uf_readBank", 32'(readBank), 32'd0);
    checkValue("uf_fullCount", 32'(fullCount), 32'd0);

    // Reset in the middle of a frame.
    applyReset();
    pushFrame(0, 30);
    applyReset();
    checkReset("rst_mid");
    pushPixel(0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
